// File: rtl/xts_block_sequencer_pkg.sv
// Shared types and constants for the XTS-AES-256 block sequencer.
//   state_e   : sequencer FSM states
//   GF_POLY   : reduction byte for the GF(2^128) doubling of the tweak
//   KEY_DATA  : key-half select for data blocks (key 1)
//   KEY_TWEAK : key-half select for the tweak job (key 2)
package xts_pkg;

  typedef enum logic [2:0] {
    DRAIN   = 3'd0,
    IDLE    = 3'd1,
    ISSUE   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4,
    OUT     = 3'd5
  } state_e;

  localparam logic [7:0] GF_POLY   = 8'h87;
  localparam logic       KEY_DATA  = 1'b0;
  localparam logic       KEY_TWEAK = 1'b1;

endpackage

// File: rtl/xts_block_sequencer_if.sv
// Bus bundle between the XTS sequencer, its upstream/downstream and the AES core.
//   Sector command : inSectorWr, inSectorData, outSectorReady
//   Plaintext in   : inDataValid, inDataData, outDataReady
//   Ciphertext out : outResValid, outResData, inResReady, outBlockIdx
//   AES core side  : outAesDataWr, outAesData, outAesKeySel, inAesData, inAesBusy
// slave  = the sequencer, master = everything around it.
interface xts_block_sequencer_if #(
  parameter int MAX_BLOCKS = 256
) ();
  localparam int IDX_W = $clog2(MAX_BLOCKS) + 1;

  logic             inSectorWr;
  logic [127:0]     inSectorData;
  logic             outSectorReady;
  logic             inDataValid;
  logic [127:0]     inDataData;
  logic             outDataReady;
  logic             outResValid;
  logic [127:0]     outResData;
  logic             inResReady;
  logic [IDX_W-1:0] outBlockIdx;
  logic             outAesDataWr;
  logic [127:0]     outAesData;
  logic             outAesKeySel;
  logic [127:0]     inAesData;
  logic             inAesBusy;

  modport slave (
    input  inSectorWr, inSectorData, inDataValid, inDataData, inResReady,
           inAesData, inAesBusy,
    output outSectorReady, outDataReady, outResValid, outResData, outBlockIdx,
           outAesDataWr, outAesData, outAesKeySel
  );

  modport master (
    output inSectorWr, inSectorData, inDataValid, inDataData, inResReady,
           inAesData, inAesBusy,
    input  outSectorReady, outDataReady, outResValid, outResData, outBlockIdx,
           outAesDataWr, outAesData, outAesKeySel
  );
endinterface

// File: rtl/xts_block_sequencer_gf_double.sv
// Combinational multiply-by-alpha of an XTS tweak in GF(2^128).
//   din  : tweak, bus byte order (byte 0 = bits [127:120]), little-endian value
//   dout : din * alpha
// Each byte shifts left by one with the MSB of byte k carried into bit 0 of
// byte k+1; the bit falling out of byte 15 folds back into byte 0 as 0x87.
module xts_gf_double
  import xts_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);

  logic [15:0] msb;

  for (genvar k = 0; k < 16; k++) begin : g_byte
    assign msb[k] = din[127-8*k];
    if (k == 0) begin : g_lsb
      assign dout[127:120] = {din[126:120], 1'b0} ^ (msb[15] ? GF_POLY : 8'h00);
    end else begin : g_mid
      assign dout[127-8*k -: 8] = {din[126-8*k -: 7], msb[k-1]};
    end
  end

endmodule

// File: rtl/xts_block_sequencer.sv
// XTS-AES-256 sector sequencer wrapped around a single-block AES-256 core.
//   inClk, inRst : clock, synchronous active-high reset
//   bus (slave)  : sector command, plaintext in, ciphertext out, AES core port
// A sector command encrypts the sector number under key 2 to form tweak T.
// Each plaintext block P is sent to the core as P^T under key 1; the core
// result R yields C = R^T, and T is doubled once C has been handed off.
// Only one block is in flight; whole 128-bit blocks only.
module xts_block_sequencer
  import xts_pkg::*;
#(
  parameter int MAX_BLOCKS = 256
) (
  input  logic               inClk,
  input  logic               inRst,
  xts_block_sequencer_if.slave bus
);

  localparam int               IDX_W   = $clog2(MAX_BLOCKS) + 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_BLOCKS);

  state_e           state;
  logic [127:0]     tweak;
  logic [127:0]     tweak_dbl;
  logic             tweak_vld;
  logic [127:0]     aes_data;
  logic             key_sel;
  logic [127:0]     res_data;
  logic [IDX_W-1:0] blk_idx;
  logic             data_rdy;

  xts_gf_double u_gf_double (
    .din  (tweak),
    .dout (tweak_dbl)
  );

  // Once the sector's block budget is used, data stays blocked until the
  // next sector command resets the counter.
  assign data_rdy = (state == IDLE) && tweak_vld && (blk_idx < IDX_MAX);

  always_ff @(posedge inClk) begin
    if (inRst) begin
      state     <= DRAIN;
      tweak     <= '0;
      tweak_vld <= 1'b0;
      aes_data  <= '0;
      key_sel   <= KEY_DATA;
      res_data  <= '0;
      blk_idx   <= '0;
    end else begin
      case (state)
        // The core has no reset of its own: let any job it was running end
        // before we issue anything new.
        DRAIN: if (!bus.inAesBusy) state <= IDLE;

        IDLE: begin
          if (bus.inSectorWr) begin
            aes_data  <= bus.inSectorData;
            key_sel   <= KEY_TWEAK;
            tweak_vld <= 1'b0;
            blk_idx   <= '0;
            state     <= ISSUE;
          end else if (bus.inDataValid && data_rdy) begin
            aes_data <= bus.inDataData ^ tweak;
            key_sel  <= KEY_DATA;
            state    <= ISSUE;
          end
        end

        ISSUE: state <= WAIT_HI;

        // Busy must be seen high before low counts as completion.
        WAIT_HI: if (bus.inAesBusy) state <= WAIT_LO;

        WAIT_LO: begin
          if (!bus.inAesBusy) begin
            if (key_sel == KEY_TWEAK) begin
              tweak     <= bus.inAesData;
              tweak_vld <= 1'b1;
              state     <= IDLE;
            end else begin
              res_data <= bus.inAesData ^ tweak;
              state    <= OUT;
            end
          end
        end

        OUT: begin
          if (bus.inResReady) begin
            tweak   <= tweak_dbl;
            blk_idx <= blk_idx + IDX_W'(1);
            state   <= IDLE;
          end
        end

        default: state <= DRAIN;
      endcase
    end
  end

  assign bus.outSectorReady = (state == IDLE);
  assign bus.outDataReady   = data_rdy;
  assign bus.outResValid    = (state == OUT);
  assign bus.outResData     = res_data;
  assign bus.outBlockIdx    = blk_idx;
  assign bus.outAesDataWr   = (state == ISSUE);
  assign bus.outAesData     = aes_data;
  assign bus.outAesKeySel   = key_sel;

endmodule

// File: tb/tb_xts_block_sequencer.sv
// Self-checking bench for xts_block_sequencer plus a unit check of xts_gf_double.
// A behavioural core model answers AES jobs; expected core requests and
// ciphertexts are queued at stimulus time and compared when they appear.
module tb_xts_block_sequencer;

  localparam int MB       = 8;
  localparam int CORE_LAT = 10;

  logic inClk = 1'b0;
  logic inRst = 1'b1;
  always #5 inClk = ~inClk;

  xts_block_sequencer_if #(.MAX_BLOCKS(MB)) bus ();

  xts_block_sequencer #(.MAX_BLOCKS(MB)) dut (
    .inClk (inClk),
    .inRst (inRst),
    .bus   (bus)
  );

  logic [127:0] gf_in, gf_out;
  xts_gf_double u_gf (.din(gf_in), .dout(gf_out));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // ---------------- reference functions ----------------
  function automatic logic [127:0] brev(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = x[127-8*k -: 8];
    return r;
  endfunction

  // Tweak doubling on the little-endian integer value.
  function automatic logic [127:0] gf_ref(input logic [127:0] t);
    logic [127:0] v;
    logic         c;
    v = brev(t);
    c = v[127];
    v = v << 1;
    if (c) v[7:0] = v[7:0] ^ 8'h87;
    return brev(v);
  endfunction

  bit core_ident = 1'b1;
  function automatic logic [127:0] core_f(input logic [127:0] x, input logic key);
    if (core_ident) return x;
    return {x[114:0], x[127:115]} ^ (key ? 128'h3141_5926_5358_9793_2384_6264_3383_2795
                                         : 128'h2718_2818_2845_9045_2353_6028_7471_3526);
  endfunction

  // ---------------- scoreboard ----------------
  logic [128:0] exp_aes[$];   // {key_sel, data} expected at the core port
  logic [127:0] exp_res[$];   // expected ciphertext
  logic [127:0] tm;           // bench copy of the tweak
  int           exp_idx = 0;
  int           n_res   = 0;
  int           stall   = 0;
  bit           rand_stall = 1'b0;

  // ---------------- AES core model ----------------
  bit           core_force  = 1'b1;
  bit           hold_chk_en = 1'b1;
  logic [127:0] core_in;
  logic         core_key;
  int           core_cnt = 0;

  always @(negedge inClk) begin : p_core
    logic [128:0] e;
    if (core_force) begin
      bus.inAesBusy = 1'b1;
    end else if (core_cnt > 0) begin
      if (hold_chk_en)
        chk("aes_hold", {bus.outAesKeySel, bus.outAesData}, {core_key, core_in});
      core_cnt--;
      if (core_cnt == 0) begin
        bus.inAesBusy = 1'b0;
        bus.inAesData = core_f(core_in, core_key);
      end
    end else begin
      bus.inAesBusy = 1'b0;
      if (bus.outAesDataWr) begin
        if (exp_aes.size() == 0) begin
          chk("aes_unexp", bus.outAesDataWr, 1'b0);
        end else begin
          e = exp_aes.pop_front();
          chk("aes_key", bus.outAesKeySel, e[128]);
          chk("aes_data", bus.outAesData, e[127:0]);
        end
        core_in       = bus.outAesData;
        core_key      = bus.outAesKeySel;
        core_cnt      = CORE_LAT;
        bus.inAesBusy = 1'b1;
      end
    end
  end

  // ---------------- ciphertext sink ----------------
  always @(negedge inClk) begin : p_sink
    if (bus.outResValid) begin
      if (exp_res.size() == 0) begin
        chk("res_unexp", bus.outResValid, 1'b0);
        bus.inResReady = 1'b0;
      end else if (stall > 0) begin
        stall--;
        bus.inResReady = 1'b0;
        chk("res_hold", bus.outResData, exp_res[0]);
      end else begin
        chk("res_data", bus.outResData, exp_res.pop_front());
        chk("res_idx", bus.outBlockIdx, exp_idx);
        exp_idx++;
        n_res++;
        bus.inResReady = 1'b1;
        stall = rand_stall ? int'($urandom_range(0, 7)) : 0;
      end
    end else begin
      bus.inResReady = 1'b0;
    end
  end

  // ---------------- stimulus tasks (entered at a negedge) ----------------
  task automatic send_sector(input logic [127:0] s);
    for (int i = 0; i < 400 && !bus.outSectorReady; i++) @(negedge inClk);
    chk("sec_rdy", bus.outSectorReady, 1'b1);
    exp_aes.push_back({1'b1, s});
    tm      = core_f(s, 1'b1);
    exp_idx = 0;
    bus.inSectorWr   = 1'b1;
    bus.inSectorData = s;
    @(negedge inClk);
    bus.inSectorWr = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] p);
    logic [127:0] x;
    for (int i = 0; i < 400 && !bus.outDataReady; i++) @(negedge inClk);
    chk("data_rdy", bus.outDataReady, 1'b1);
    x = p ^ tm;
    exp_aes.push_back({1'b0, x});
    exp_res.push_back(core_f(x, 1'b0) ^ tm);
    tm = gf_ref(tm);
    bus.inDataValid = 1'b1;
    bus.inDataData  = p;
    @(negedge inClk);
    bus.inDataValid = 1'b0;
  endtask

  task automatic wait_res(input int n);
    for (int i = 0; i < 3000 && n_res < n; i++) @(negedge inClk);
    chk("res_count", n_res, n);
    @(negedge inClk);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- main sequence ----------------
  initial begin : p_main
    int nres_before;
    logic [127:0] v;
    bus.inSectorWr   = 1'b0;
    bus.inSectorData = '0;
    bus.inDataValid  = 1'b0;
    bus.inDataData   = '0;

    // xts_gf_double unit checks
    gf_in = 128'h0000_0000_0000_0000_0000_0000_0000_0080; #1;
    chk("gf_wrap", gf_out, 128'h8700_0000_0000_0000_0000_0000_0000_0000);
    gf_in = 128'h0100_0000_0000_0000_0000_0000_0000_0000; #1;
    chk("gf_shift", gf_out, 128'h0200_0000_0000_0000_0000_0000_0000_0000);
    gf_in = {128{1'b1}}; #1;
    chk("gf_ones", gf_out, 128'h79ff_ffff_ffff_ffff_ffff_ffff_ffff_ffff);
    for (int i = 0; i < 4; i++) begin
      v = rnd128();
      gf_in = v; #1;
      chk("gf_rand", gf_out, gf_ref(v));
    end

    // Reset with the core busy
    repeat (3) @(negedge inClk);
    chk("rst_sec_rdy",  bus.outSectorReady, 1'b0);
    chk("rst_data_rdy", bus.outDataReady,   1'b0);
    chk("rst_res_vld",  bus.outResValid,    1'b0);
    chk("rst_res_data", bus.outResData,     '0);
    chk("rst_idx",      bus.outBlockIdx,    '0);
    chk("rst_aes_wr",   bus.outAesDataWr,   1'b0);
    chk("rst_aes_data", bus.outAesData,     '0);
    chk("rst_key_sel",  bus.outAesKeySel,   1'b0);
    inRst = 1'b0;
    repeat (4) begin
      @(negedge inClk);
      chk("drain_hold", bus.outSectorReady, 1'b0);
    end
    @(posedge inClk);
    core_force = 1'b0;            // busy drops at the next negedge
    @(negedge inClk);
    chk("drain_early", bus.outSectorReady, 1'b0);
    @(negedge inClk);
    chk("drain_exit", bus.outSectorReady, 1'b1);

    // Sector 0 with an identity core: T = 0, C = P
    send_sector('0);
    send_block(128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff);
    wait_res(1);
    chk("idx_after_1", bus.outBlockIdx, 1);

    // Sector and data in the same IDLE cycle: sector goes first,
    // the held data block follows under the new tweak.
    core_ident = 1'b0;
    rand_stall = 1'b1;
    chk("prio_data_rdy", bus.outDataReady, 1'b1);
    v = 128'hff00_0000_0000_0000_0000_0000_0000_0000;
    exp_aes.push_back({1'b1, v});
    tm      = core_f(v, 1'b1);
    exp_idx = 0;
    bus.inSectorWr   = 1'b1;
    bus.inSectorData = v;
    bus.inDataValid  = 1'b1;
    bus.inDataData   = 128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f;
    @(negedge inClk);
    bus.inSectorWr = 1'b0;
    send_block(128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f);
    for (int i = 1; i < MB; i++) send_block(rnd128());
    wait_res(1 + MB);

    // Block budget exhausted: data held off until the next sector
    bus.inDataValid = 1'b1;
    bus.inDataData  = rnd128();
    repeat (20) begin
      @(negedge inClk);
      chk("limit_rdy", bus.outDataReady, 1'b0);
    end
    chk("limit_idx", bus.outBlockIdx, MB);
    bus.inDataValid = 1'b0;
    send_sector(rnd128());
    chk("new_sec_idx", bus.outBlockIdx, 0);
    chk("new_sec_rdy", bus.outDataReady, 1'b0);
    send_block(rnd128());
    send_block(rnd128());
    wait_res(3 + MB);

    // Reset while the core works on a data block
    send_sector(rnd128());
    send_block(rnd128());
    for (int i = 0; i < 100 && !bus.outAesDataWr; i++) @(negedge inClk);
    chk("abort_issue", bus.outAesDataWr, 1'b1);
    hold_chk_en = 1'b0;
    repeat (4) @(negedge inClk);
    nres_before = n_res;
    inRst = 1'b1;
    @(negedge inClk);
    inRst = 1'b0;
    exp_res.delete();
    chk("abort_drain", bus.outSectorReady, 1'b0);
    repeat (15) begin
      @(negedge inClk);
      chk("abort_no_res", bus.outResValid, 1'b0);
    end
    chk("abort_res_cnt", n_res, nres_before);
    chk("abort_aes_q", exp_aes.size(), 0);
    hold_chk_en = 1'b1;

    // Next sector after the abort
    send_sector(rnd128());
    send_block(rnd128());
    send_block(rnd128());
    wait_res(5 + MB);
    chk("final_idx", bus.outBlockIdx, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : p_watchdog
    #400000;
    $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
